// File: rtl/conv_acc_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : conv_acc_ctrl
// Brief    : Tile sequencer and channel accumulator for the 9-input adder tree,
//            with a credit-gated result FIFO. Optional macro: CONV_ACC_SAT_EN
//            (saturating output conversion instead of wrap).
// Revision : 1.0 - initial release
//==============================================================================
module conv_acc_ctrl #(
  parameter int SUM_W      = 18,
  parameter int ACC_W      = 32,
  parameter int OUT_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [7:0]              cfg_cin,
  input  logic [15:0]             cfg_npix,
  output logic                    busy,
  output logic                    done,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [SUM_W-1:0] tree_sum,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_last
);

  localparam int          c_aw    = $clog2(FIFO_DEPTH);
  localparam logic [c_aw:0] c_depth = (c_aw+1)'(FIFO_DEPTH);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_run   = 2'd1;
  localparam logic [1:0] c_drain = 2'd2;
  localparam logic [1:0] c_done  = 2'd3;

  logic [1:0]  r_state;
  logic [1:0]  w_state_next;

  logic [7:0]  r_cin;
  logic [15:0] r_npix;
  logic [7:0]  r_ch;
  logic [15:0] r_pix;

  logic        r_p1_v, r_p1_first, r_p1_last, r_p1_tlast;
  logic        r_p2_v, r_p2_first, r_p2_last, r_p2_tlast;

  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_sum_ext;
  logic signed [ACC_W-1:0] w_acc_next;
  logic signed [OUT_W-1:0] w_out_conv;

  logic [c_aw:0] r_cred;
  logic [c_aw:0] r_wr_ptr;
  logic [c_aw:0] r_rd_ptr;
  logic signed [OUT_W-1:0] r_mem_data [FIFO_DEPTH];
  logic                    r_mem_last [FIFO_DEPTH];

  logic w_ch_first;
  logic w_ch_last;
  logic w_pix_last;
  logic w_accept;
  logic w_cfg_zero;
  logic w_push;
  logic w_pop;
  logic w_fifo_empty;
  logic w_pipe_empty;

  assign w_ch_first   = (r_ch == 8'd0);
  assign w_ch_last    = (r_ch == r_cin - 8'd1);
  assign w_pix_last   = (r_pix == r_npix - 16'd1);
  assign w_accept     = in_valid & in_ready;
  assign w_cfg_zero   = (cfg_cin == 8'd0) | (cfg_npix == 16'd0);
  assign w_push       = r_p2_v & r_p2_last;
  assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
  assign w_pop        = out_valid & out_ready;
  assign w_pipe_empty = ~r_p1_v & ~r_p2_v;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_idle: begin
        if (start) begin
          w_state_next = w_cfg_zero ? c_done : c_run;
        end
      end
      c_run: begin
        if (w_accept && w_ch_last && w_pix_last) begin
          w_state_next = c_drain;
        end
      end
      c_drain: begin
        if (w_pipe_empty && (r_cred == '0) && w_fifo_empty) begin
          w_state_next = c_done;
        end
      end
      c_done: begin
        w_state_next = c_idle;
      end
      default: begin
        w_state_next = c_idle;
      end
    endcase
  end

  // in_ready depends only on registered state; a pop frees its credit a cycle later
  always_comb begin
    busy     = (r_state != c_idle);
    done     = (r_state == c_done);
    in_ready = (r_state == c_run) && (!w_ch_last || (r_cred < c_depth));
  end

  // ------------------------------------------------------- tile counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cin  <= 8'd0;
      r_npix <= 16'd0;
      r_ch   <= 8'd0;
      r_pix  <= 16'd0;
    end else if ((r_state == c_idle) && start) begin
      r_cin  <= cfg_cin;
      r_npix <= cfg_npix;
      r_ch   <= 8'd0;
      r_pix  <= 16'd0;
    end else if (w_accept) begin
      if (w_ch_last) begin
        r_ch  <= 8'd0;
        r_pix <= r_pix + 16'd1;
      end else begin
        r_ch  <= r_ch + 8'd1;
      end
    end
  end

  // ---------------------------------------------- valid pipe (tree latency)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p1_v     <= 1'b0;
      r_p1_first <= 1'b0;
      r_p1_last  <= 1'b0;
      r_p1_tlast <= 1'b0;
      r_p2_v     <= 1'b0;
      r_p2_first <= 1'b0;
      r_p2_last  <= 1'b0;
      r_p2_tlast <= 1'b0;
    end else begin
      r_p1_v     <= w_accept;
      r_p1_first <= w_accept & w_ch_first;
      r_p1_last  <= w_accept & w_ch_last;
      r_p1_tlast <= w_accept & w_ch_last & w_pix_last;
      r_p2_v     <= r_p1_v;
      r_p2_first <= r_p1_first;
      r_p2_last  <= r_p1_last;
      r_p2_tlast <= r_p1_tlast;
    end
  end

  // ---------------------------------------------------------- accumulator
  assign w_sum_ext  = {{(ACC_W-SUM_W){tree_sum[SUM_W-1]}}, tree_sum};
  assign w_acc_next = r_p2_first ? w_sum_ext : (r_acc + w_sum_ext);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (r_p2_v) begin
      r_acc <= w_acc_next;
    end
  end

`ifdef CONV_ACC_SAT_EN
  // In range when every bit from the output sign bit upward agrees
  logic w_in_range;
  assign w_in_range = (&w_acc_next[ACC_W-1:OUT_W-1]) | ~(|w_acc_next[ACC_W-1:OUT_W-1]);

  always_comb begin
    w_out_conv = w_acc_next[OUT_W-1:0];
    if (!w_in_range) begin
      w_out_conv = w_acc_next[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                       : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end
`else
  assign w_out_conv = w_acc_next[OUT_W-1:0];
`endif

  // -------------------------------------------------------------- credits
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cred <= '0;
    end else begin
      case ({w_accept & w_ch_last, w_pop})
        2'b10:   r_cred <= r_cred + 1'b1;
        2'b01:   r_cred <= r_cred - 1'b1;
        default: r_cred <= r_cred;
      endcase
    end
  end

  // --------------------------------------------------------- result FIFO
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr[c_aw-1:0]] <= w_out_conv;
      r_mem_last[r_wr_ptr[c_aw-1:0]] <= r_p2_tlast;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  assign out_valid = ~w_fifo_empty;
  assign out_data  = out_valid ? r_mem_data[r_rd_ptr[c_aw-1:0]] : '0;
  assign out_last  = out_valid & r_mem_last[r_rd_ptr[c_aw-1:0]];

endmodule
`default_nettype wire

// File: tb/tb_conv_acc_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : tb_conv_acc_ctrl
// Brief    : Self-checking bench for conv_acc_ctrl; honours CONV_ACC_SAT_EN.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
module tb_conv_acc_ctrl;

  localparam int SUM_W      = 18;
  localparam int ACC_W      = 32;
  localparam int OUT_W      = 16;
  localparam int FIFO_DEPTH = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic [7:0]              cfg_cin;
  logic [15:0]             cfg_npix;
  logic                    busy;
  logic                    done;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [SUM_W-1:0] tree_sum;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_last;

  always #5 clk = ~clk;

  conv_acc_ctrl #(
    .SUM_W(SUM_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_cin(cfg_cin), .cfg_npix(cfg_npix),
    .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
    .tree_sum(tree_sum), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  int vectors     = 0;
  int miscompares = 0;

  int          sums_q[$];      // beats still to be offered, in (pixel, channel) order
  logic [16:0] exp_q[$];       // {last, data} expected at the output
  logic signed [SUM_W-1:0] t1, cur;   // tree model: value for next cycle / current cycle

  int   cyc, accepts, pops, done_cnt, last_acc_cyc, ov_rise_cyc;
  bit   ov_prev, start_req, noisy_start;
  int   vprob, rprob;
  logic [15:0] last_pop_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Expected output pixel from the full-precision channel sum
  function automatic logic [15:0] conv(input longint s);
    int a;
    a = int'(s);
`ifdef CONV_ACC_SAT_EN
    if (a > 32767) a = 32767;
    else if (a < -32768) a = -32768;
`endif
    return a[15:0];
  endfunction

  task automatic model_tile(input int cin, input int npix);
    longint s;
    for (int p = 0; p < npix; p++) begin
      s = 0;
      for (int c = 0; c < cin; c++) s += longint'(sums_q[p*cin + c]);
      exp_q.push_back({(p == npix - 1), conv(s)});
    end
  endtask

  task automatic fill_random(input int n);
    repeat (n) sums_q.push_back(int'($urandom_range(262143)) - 131072);
  endtask

  // One clock cycle: entered and left at posedge+1, outputs sampled at negedge
  task automatic one_cycle();
    bit          acc;
    logic [16:0] e;
    start = start_req;
    if (!start_req && noisy_start && busy && ($urandom_range(3) == 0)) begin
      start    = 1'b1;
      cfg_cin  = 8'($urandom);
      cfg_npix = 16'($urandom);
    end
    if (vprob < 0) in_valid = (sums_q.size() > 0) && (cyc % 2 == 0);
    else           in_valid = (sums_q.size() > 0) && (int'($urandom_range(99)) < vprob);
    out_ready = (int'($urandom_range(99)) < rprob);
    tree_sum  = cur;
    @(negedge clk);
    acc = in_valid && in_ready;
    if (acc) begin
      accepts++;
      last_acc_cyc = cyc;
    end
    if (out_valid && !ov_prev) ov_rise_cyc = cyc;
    ov_prev = out_valid;
    if (done) done_cnt++;
    if (out_valid && out_ready) begin
      pops++;
      chk("out_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        last_pop_data = $unsigned(out_data);
        chk("out_data", $unsigned(out_data), {16'd0, e[15:0]});
        chk("out_last", out_last, e[16]);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    cur = t1;
    t1  = acc ? SUM_W'(sums_q.pop_front()) : SUM_W'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    one_cycle();
    rst = 1'b0;
    sums_q.delete();
    exp_q.delete();
  endtask

  task automatic start_tile(input int cin, input int npix);
    cfg_cin     = 8'(cin);
    cfg_npix    = 16'(npix);
    accepts     = 0;
    pops        = 0;
    done_cnt    = 0;
    ov_rise_cyc = -1000;
    start_req   = 1'b1;
    one_cycle();
    start_req   = 1'b0;
  endtask

  task automatic run_to_done(input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      one_cycle();
      n++;
    end
    chk("done_seen", 32'(done_cnt != 0), 32'd1);
    chk("exp_drained", exp_q.size(), 32'd0);
    chk("beats_consumed", sums_q.size(), 32'd0);
    if (done_cnt == 0) do_reset();
    repeat (3) one_cycle();
    chk("done_once", done_cnt, 32'd1);
    chk("idle_after_done", busy, 1'b0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; cfg_cin = '0; cfg_npix = '0;
    in_valid = 1'b0; out_ready = 1'b0; tree_sum = '0;
    cur = '0; t1 = '0; cyc = 0; accepts = 0; pops = 0; done_cnt = 0;
    last_acc_cyc = 0; ov_rise_cyc = -1000; ov_prev = 1'b0;
    start_req = 1'b0; noisy_start = 1'b0; vprob = 100; rprob = 100;
    last_pop_data = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_out_data", $unsigned(out_data), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single beat, single pixel: latency and done pulse
    sums_q.push_back(9);
    model_tile(1, 1);
    vprob = 100; rprob = 100;
    start_tile(1, 1);
    run_to_done(50);
    chk("t1_latency", ov_rise_cyc - last_acc_cyc, 32'd3);
    chk("t1_value", last_pop_data, 32'd9);

    // Three channels, two pixels
    sums_q = '{9, -5, 100, 1, 1, 1};
    model_tile(3, 2);
    start_tile(3, 2);
    run_to_done(60);
    chk("t2_pops", pops, 32'd2);

    // Backpressure: credits stop acceptance at FIFO_DEPTH pixels
    fill_random(8);
    model_tile(1, 8);
    vprob = 100; rprob = 0;
    start_tile(1, 8);
    repeat (15) one_cycle();
    chk("bp_accepts", accepts, 32'd4);
    chk("bp_in_ready", in_ready, 1'b0);
    chk("bp_out_valid", out_valid, 1'b1);
    rprob = 100;
    run_to_done(100);
    chk("bp_pops", pops, 32'd8);

    // 255 channels of the maximum tree sum
    repeat (255) sums_q.push_back(131071);
    model_tile(255, 1);
    vprob = 100; rprob = 100;
    start_tile(255, 1);
    run_to_done(400);
`ifdef CONV_ACC_SAT_EN
    chk("cin255_value", last_pop_data, 32'h0000_7FFF);
`else
    chk("cin255_value", last_pop_data, 32'h0000_FF01);
`endif

    // Toggling in_valid with garbage on the tree in idle cycles
    fill_random(10);
    model_tile(2, 5);
    vprob = -1; rprob = 100;
    start_tile(2, 5);
    run_to_done(100);
    vprob = 100;

    // Zero configurations complete without output
    start_tile(0, 5);
    run_to_done(20);
    chk("zero_cin_pops", pops, 32'd0);
    start_tile(3, 0);
    run_to_done(20);
    chk("zero_npix_pops", pops, 32'd0);

    // Reset mid-tile with two results held in the FIFO
    sums_q = '{7, 8};
    vprob = 100; rprob = 0;
    start_tile(1, 8);
    repeat (8) one_cycle();
    chk("rst_mid_pre_valid", out_valid, 1'b1);
    chk("rst_mid_pre_busy", busy, 1'b1);
    chk("rst_mid_accepts", accepts, 32'd2);
    do_reset();
    chk("rst_mid_out_valid", out_valid, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_in_ready", in_ready, 1'b0);

    // Random tiles, with stray start pulses while busy
    for (int k = 0; k < 6; k++) begin
      int cin, npix;
      cin   = int'($urandom_range(5, 1));
      npix  = int'($urandom_range(12, 1));
      vprob = int'($urandom_range(100, 40));
      rprob = int'($urandom_range(100, 20));
      fill_random(cin * npix);
      model_tile(cin, npix);
      start_tile(cin, npix);
      noisy_start = 1'b1;
      run_to_done(2000);
      noisy_start = 1'b0;
      chk("rand_pops", pops, npix);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv_acc_ctrl.md
# conv_acc_ctrl

Controller and accumulator for the 9-input INT8-product adder tree used by the 3x3 convolution engine. It admits one 3x3 window of products per beat, tracks each beat through the tree's fixed 2-cycle pipeline, and accumulates tree sums across `cfg_cin` input channels. It then emits one accumulated pixel per window position through a small result FIFO with valid/ready. It sits between the window/product generator and the output writeback path, and owns tile-level sequencing (start/busy/done).

## Interface
- `SUM_W`, 18: width of the adder tree output.
- `ACC_W`, 32: internal accumulator width, two's complement.
- `OUT_W`, 16: output pixel width.
- `FIFO_DEPTH`, 4: result FIFO entries; power of two, ≥2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: pulse; latches cfg when in IDLE, ignored otherwise.
- `cfg_cin` in 8: channels per pixel, 0..255.
- `cfg_npix` in 16: pixels per tile, 0..65535.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle pulse at tile completion.
- `in_valid` in 1: product set for the current (pixel, channel) is on the tree inputs.
- `in_ready` out 1: beat accepted when `in_valid & in_ready`.
- `tree_sum` in SUM_W signed: registered output of the adder tree.
- `out_valid` out 1: FIFO head valid.
- `out_ready` in 1: downstream pop.
- `out_data` out OUT_W signed: accumulated pixel.
- `out_last` out 1: head is the last pixel of the tile.

## Operation
- FSM IDLE → RUN → DRAIN → DONE → IDLE.
- IDLE: on `start`, latch `cfg_cin`/`cfg_npix` and clear the channel and pixel counters. If either is 0, go directly to DONE with no outputs; otherwise go to RUN.
- RUN: each accepted beat increments channel counter `ch`. At `ch == cin-1`, `ch` wraps to 0 and the pixel counter increments. Acceptance of the final beat of the final pixel moves to DRAIN.
- DRAIN: `in_ready` = 0. Exit to DONE when the valid pipe is empty, no pixel is in flight, and the FIFO is empty (all results popped).
- DONE: `done` = 1 for one cycle, then IDLE.
- Valid pipe: 2-stage shift register of {valid, first (ch==0), last (ch==cin-1), tile_last}, loaded with the accept strobe. Non-accepted cycles load valid=0. The tree is free-running; its sums for those cycles are discarded.
- Accumulate stage, at pipe stage 2: `acc <= first ? sext(tree_sum) : acc + sext(tree_sum)`, mod 2^ACC_W. If `last`, push `acc_next` (with `tile_last`) into the FIFO.
- Credits: `cred` = pixels whose last beat is accepted but not yet pushed, plus FIFO occupancy. A beat with `ch == cin-1` is only accepted when `cred < FIFO_DEPTH`. Non-last beats are always accepted in RUN. The FIFO therefore never overflows.
- `in_ready` is decoded from registered state only. There is no combinational path from `out_ready`. A pop in the same cycle does not free a credit until the next cycle.
- Output conversion: see Configuration.

## Timing
- Reset values: state IDLE; `busy`, `done`, `in_ready`, `out_valid`, `out_last` = 0; `out_data` = 0; counters, acc, valid pipe, FIFO pointers = 0.
- Beat accepted in cycle T: its `tree_sum` is sampled in cycle T+2.
- When the FIFO is empty, a pixel's last beat accepted in T gives `out_valid` in T+3.
- Throughput: 1 beat/cycle with no backpressure.
- FIFO: push and pop in the same cycle keep occupancy unchanged. Output order equals pixel order.
- `rst` mid-tile: immediate return to IDLE, FIFO flushed, pipe cleared. Stale `tree_sum` values are ignored because the pipe is clear.
- A `start` pulse while busy has no effect.

## Configuration
- `CONV_ACC_SAT_EN` defined: `out_data` = acc clamped to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
- Not defined: `out_data` = acc[OUT_W−1:0] (wrap).
- Accumulator behaviour is identical in both builds.

## Test plan
- cin=1, npix=1, tree_sum=9 two cycles after accept → `out_data`=9, `out_last`=1, `out_valid` 3 cycles after accept. After pop, `done` pulses once.
- cin=3, npix=2, sums 9, −5, 100 then 1, 1, 1 → outputs 104 then 3, in order. `out_last` only on 3.
- cin=1, npix=8, FIFO_DEPTH=4, `out_ready`=0 → exactly 4 beats accepted, then `in_ready`=0. Raise `out_ready` → 8 results in order, `done` after the 8th pop.
- cin=255, every tree_sum = 131071 → with `CONV_ACC_SAT_EN`: 32767. Without: 0xFF01 (−255).
- `in_valid` toggling every cycle with garbage `tree_sum` on idle cycles, cin=2 → only accepted-beat sums accumulated.
- Assert `rst` in RUN with 2 results in the FIFO → next cycle `out_valid`=0, `busy`=0. A new `start` runs cleanly.
